// File: rtl/twenty_bit_serial_adder.sv
// Digit-serial 20-bit unsigned adder, LSD first, start/busy/done handshake.
// DIGIT_WIDTH must divide 20; one digit is added per clock.
module twenty_bit_serial_adder #(
  parameter int DIGIT_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] i0,
  input  logic [19:0] i1,
  output logic [19:0] s,
  output logic        cout,
  output logic        busy,
  output logic        done
);

  localparam int DW = DIGIT_WIDTH;
  localparam int N  = 20 / DW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE,
    S_ADD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [19:0]   r_op0;
  logic [19:0]   r_op1;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [19:0]   r_s;
  logic          r_cout;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_step;
  logic          w_last;
  logic [DW:0]   w_sum;
  logic [19:0]   w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start)  w_next = S_ADD;
      S_ADD:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == S_IDLE) && start;
    w_step   = (r_state == S_ADD);
    w_last   = w_step && (r_cnt == CW'(N - 1));
  end

  assign w_sum = {1'b0, r_op0[DW-1:0]}
               + {1'b0, r_op1[DW-1:0]}
               + {{DW{1'b0}}, r_carry};

  // Only the upper 20-DW accumulator bits survive a shift,
  // so the bottom digit is never stored.
  if (DW == 20) begin : g_single
    assign w_acc_next = w_sum[DW-1:0];
  end else begin : g_acc
    logic [19-DW:0] r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
      end else if (w_step) begin
        r_acc <= w_acc_next[19:DW];
      end
    end

    assign w_acc_next = {w_sum[DW-1:0], r_acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op0   <= '0;
      r_op1   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op0   <= i0;
        r_op1   <= i1;
        r_carry <= 1'b0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (w_step) begin
        r_op0   <= r_op0 >> DW;
        r_op1   <= r_op1 >> DW;
        r_carry <= w_sum[DW];
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_s    <= w_acc_next;
          r_cout <= w_sum[DW];
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_twenty_bit_serial_adder.sv
// Scoreboard bench for twenty_bit_serial_adder at DIGIT_WIDTH 4, 1 and 20.
// Index 0: DW=4, index 1: DW=1, index 2: DW=20.
module tb_twenty_bit_serial_adder;

  logic             clk;
  logic             rst_n;
  logic [19:0]      i0;
  logic [19:0]      i1;
  logic [2:0]       start_v;
  logic [2:0]       busy_v;
  logic [2:0]       cout_v;
  logic [2:0]       done_v;
  logic [2:0][19:0] s_v;

  int total = 0;
  int bad   = 0;
  int lat[3] = '{5, 20, 1};
  int dcount[3] = '{0, 0, 0};

  logic [20:0] q0[$];
  logic [20:0] q1[$];
  logic [20:0] q2[$];
  logic [20:0] mon_e;
  logic [20:0] mon_got;
  logic        mon_have;
  logic [2:0]  prev_done = '0;

  twenty_bit_serial_adder #(.DIGIT_WIDTH(4)) u_dw4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .i0(i0), .i1(i1), .s(s_v[0]), .cout(cout_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  twenty_bit_serial_adder #(.DIGIT_WIDTH(1)) u_dw1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .i0(i0), .i1(i1), .s(s_v[1]), .cout(cout_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  twenty_bit_serial_adder #(.DIGIT_WIDTH(20)) u_dw20 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .i0(i0), .i1(i1), .s(s_v[2]), .cout(cout_v[2]),
    .busy(busy_v[2]), .done(done_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (done_v[k]) begin
          dcount[k]++;
          total++;
          if (prev_done[k]) begin
            bad++;
            $display("FAIL done_pulse[%0d]: done high two cycles", k);
          end
          mon_have = 1'b0;
          mon_e    = '0;
          case (k)
            0: if (q0.size() > 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
            1: if (q1.size() > 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
            default: if (q2.size() > 0) begin mon_e = q2.pop_front(); mon_have = 1'b1; end
          endcase
          mon_got = {cout_v[k], s_v[k]};
          total++;
          if (!mon_have) begin
            bad++;
            $display("FAIL sb_unexpected[%0d]: done with got=%h, none expected",
                     k, mon_got);
          end else if (mon_got !== mon_e) begin
            bad++;
            $display("FAIL sb_result[%0d]: got {cout,s}=%h want %h",
                     k, mon_got, mon_e);
          end
        end
      end
    end
    prev_done = done_v;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [19:0] a, input logic [19:0] b);
    logic [20:0] e;
    e = {1'b0, a} + {1'b0, b};
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic go(input int k, input logic [19:0] a, input logic [19:0] b);
    i0 = a;
    i1 = b;
    start_v[k] = 1'b1;
    push(k, a, b);
    tick();
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int cyc);
    cyc = 0;
    while (!done_v[k] && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!done_v[k]) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_v = '0;
    i0      = '0;
    i1      = '0;
    repeat (2) tick();
    total++;
    if ({s_v, cout_v, busy_v, done_v} !== '0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", {s_v, cout_v, busy_v, done_v});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if ({s_v, cout_v, busy_v, done_v} !== '0) begin
        bad++;
        $display("FAIL idle_stable c%0d: got %h want 0", c,
                 {s_v, cout_v, busy_v, done_v});
      end
    end
  endtask

  task automatic test_basic();
    int cyc;
    go(0, 20'd72, 20'd27);
    total++;
    if (busy_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: got %b want 1", busy_v[0]);
    end
    wait_done(0, cyc);
    total++;
    if (cyc != 5) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 5", cyc);
    end
    total++;
    if (s_v[0] !== 20'd99 || cout_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got s=%0d c=%b b=%b want 99 0 0",
               s_v[0], cout_v[0], busy_v[0]);
    end
    repeat (3) tick();
    total++;
    if (s_v[0] !== 20'd99 || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold: got s=%0d d=%b want 99 0", s_v[0], done_v[0]);
    end
  endtask

  task automatic test_edges();
    logic [19:0] a[3]  = '{20'hFFFFF, 20'hFFFFF, 20'h00000};
    logic [19:0] b[3]  = '{20'h00001, 20'hFFFFF, 20'h00000};
    logic [19:0] es[3] = '{20'h00000, 20'hFFFFE, 20'h00000};
    logic        ec[3] = '{1'b1, 1'b1, 1'b0};
    logic [19:0] prev;
    int cyc;
    prev = 20'd99;
    for (int t = 0; t < 3; t++) begin
      go(0, a[t], b[t]);
      i0 = 20'h5A5A5;
      i1 = 20'hA5A5A;
      tick();
      total++;
      if (s_v[0] !== prev) begin
        bad++;
        $display("FAIL edge_hold t%0d: got %h want %h", t, s_v[0], prev);
      end
      wait_done(0, cyc);
      total++;
      if (cyc != 4 || s_v[0] !== es[t] || cout_v[0] !== ec[t]) begin
        bad++;
        $display("FAIL edge_result t%0d: got cyc=%0d s=%h c=%b want 4 %h %b",
                 t, cyc, s_v[0], cout_v[0], es[t], ec[t]);
      end
      prev = es[t];
      tick();
    end
  endtask

  task automatic test_ignore();
    int cyc;
    int d0;
    d0 = dcount[0];
    go(0, 20'd110, 20'd110);
    tick();
    i0 = 20'd1;
    i1 = 20'd1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_done(0, cyc);
    total++;
    if (cyc != 3 || s_v[0] !== 20'd220 || cout_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL ignore_result: got cyc=%0d s=%0d want 3 220", cyc, s_v[0]);
    end
    repeat (8) tick();
    total++;
    if (dcount[0] - d0 != 1 || busy_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL ignore_count: got %0d dones busy=%b want 1 0",
               dcount[0] - d0, busy_v[0]);
    end
  endtask

  task automatic test_abort();
    int cyc;
    int d0;
    d0 = dcount[0];
    go(0, 20'd5, 20'd7);
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (s_v[0] !== '0 || cout_v[0] !== 1'b0 || busy_v[0] !== 1'b0
        || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: got s=%h c=%b b=%b d=%b want 0",
               s_v[0], cout_v[0], busy_v[0], done_v[0]);
    end
    tick();
    rst_n = 1'b1;
    q0.delete();
    repeat (10) tick();
    total++;
    if (dcount[0] != d0 || busy_v[0] !== 1'b0 || s_v[0] !== '0) begin
      bad++;
      $display("FAIL abort_nodone: got dones=%0d b=%b s=%h want 0 0 0",
               dcount[0] - d0, busy_v[0], s_v[0]);
    end
    go(0, 20'd3, 20'd4);
    wait_done(0, cyc);
    total++;
    if (cyc != 5 || s_v[0] !== 20'd7) begin
      bad++;
      $display("FAIL abort_next: got cyc=%0d s=%0d want 5 7", cyc, s_v[0]);
    end
    tick();
  endtask

  task automatic test_back_to_back(input int k);
    int c1;
    int c2;
    i0 = 20'd1;
    i1 = 20'd2;
    start_v[k] = 1'b1;
    push(k, 20'd1, 20'd2);
    tick();
    total++;
    if (busy_v[k] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy[%0d]: got %b want 1", k, busy_v[k]);
    end
    wait_done(k, c1);
    total++;
    if (c1 != lat[k] || s_v[k] !== 20'd3) begin
      bad++;
      $display("FAIL b2b_first[%0d]: got cyc=%0d s=%0d want %0d 3",
               k, c1, s_v[k], lat[k]);
    end
    i0 = 20'd10;
    i1 = 20'd20;
    push(k, 20'd10, 20'd20);
    tick();
    total++;
    if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_reissue[%0d]: got b=%b d=%b want 1 0",
               k, busy_v[k], done_v[k]);
    end
    wait_done(k, c2);
    total++;
    if (c2 + 1 != lat[k] + 1 || s_v[k] !== 20'd30 || cout_v[k] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second[%0d]: got gap=%0d s=%0d want %0d 30",
               k, c2 + 1, s_v[k], lat[k] + 1);
    end
    start_v[k] = 1'b0;
    tick();
    total++;
    if (busy_v[k] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop[%0d]: got busy=%b want 0", k, busy_v[k]);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_ignore();
    test_abort();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    repeat (3) tick();
    total++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
